// File: rtl/pwm_breathe_pkg.sv
// Shared types and 12 MHz board defaults for the breathing-LED sequencer.
// Optional build macro used by this slice: PWM_BREATHE_GAMMA_EN (see pwm_gen).
package pwm_breathe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_HI   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_LO   = 3'd4
  } state_t;

  // 0->255 in unit steps takes ~0.5 s at 12 MHz with this divider
  localparam int unsigned DEF_DIV_12M  = 23529;
  localparam int unsigned DEF_STEP_12M = 1;
  localparam int unsigned DEF_HOLD_12M = 8;

  // Full-scale duty; also the PWM period in clocks
  function automatic int unsigned duty_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_breathe_seq_pwm_gen.sv
// PWM generator: free-running period counter, duty latched at the period
// boundary, registered compare output.
// Build macro PWM_BREATHE_GAMMA_EN: latch a square-law corrected duty.
module pwm_gen
  import pwm_breathe_pkg::*;
#(
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(duty_max(DUTY_W));
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(duty_max(DUTY_W) - 1);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] duty_act;
  logic [DUTY_W-1:0] duty_eff;

`ifdef PWM_BREATHE_GAMMA_EN
  logic [2*DUTY_W-1:0] duty_sq;

  // Square-law correction; full scale kept exact so it stays always-on
  always_comb begin
    duty_sq  = {{DUTY_W{1'b0}}, duty} * {{DUTY_W{1'b0}}, duty};
    duty_eff = (duty == DUTY_TOP) ? DUTY_TOP : duty_sq[2*DUTY_W-1:DUTY_W];
  end
`else
  // Linear duty straight through
  always_comb begin
    duty_eff = duty;
  end
`endif

  // Period counter 0..2^W-2, duty latched on wrap, compare registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty_act);
      if (cnt == CNT_LAST) begin
        cnt      <= '0;
        duty_act <= duty_eff;
      end else begin
        cnt <= cnt + DUTY_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_breathe_seq.sv
// Breathing-envelope sequencer: ramp up, hold high, ramp down, hold low,
// driving an embedded PWM generator and an active-low LED pin.
// Build macro PWM_BREATHE_GAMMA_EN selects gamma-corrected PWM in pwm_gen.
module pwm_breathe_seq
  import pwm_breathe_pkg::*;
#(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned HOLD_W   = 8,
  parameter int unsigned DEF_DIV  = DEF_DIV_12M,
  parameter int unsigned DEF_STEP = DEF_STEP_12M,
  parameter int unsigned DEF_HOLD = DEF_HOLD_12M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_stb,
  output logic              pwm_out,
  output logic              nLED,
  output logic [2:0]        state,
  output logic              cycle_done
);

  localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(duty_max(DUTY_W));

  state_t            st;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] step_r;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_cnt;
  logic              tick;
  logic              hold_last;
  logic              pwm_clr;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] up_next;
  logic [DUTY_W-1:0] dn_next;

  assign cfg_ready = (st == ST_IDLE);
  assign state     = st;
  assign nLED      = ~pwm_out;
  // Clearing on !en as well lets the forced-low PWM land on the same edge as IDLE
  assign pwm_clr   = (st == ST_IDLE) || !en;

  // Config registers, accepted only while idle; zero fields coerced to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= DIV_W'(DEF_DIV);
      step_r <= DUTY_W'(DEF_STEP);
      hold_r <= HOLD_W'(DEF_HOLD);
    end else if (cfg_valid && cfg_ready) begin
      div_r  <= (cfg_div  == '0) ? DIV_W'(1)  : cfg_div;
      step_r <= (cfg_step == '0) ? DUTY_W'(1) : cfg_step;
      hold_r <= (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;
    end
  end

  // Tick prescaler, parked at zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (st == ST_IDLE || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + DIV_W'(1);
    end
  end

  // Tick strobe, saturating ramp arithmetic and hold terminal count
  always_comb begin
    tick      = (st != ST_IDLE) && (pre_cnt == div_r - DIV_W'(1));
    up_sum    = {1'b0, duty} + {1'b0, step_r};
    dn_diff   = {1'b0, duty} - {1'b0, step_r};
    up_next   = up_sum[DUTY_W] ? DUTY_TOP : up_sum[DUTY_W-1:0];
    dn_next   = dn_diff[DUTY_W] ? '0 : dn_diff[DUTY_W-1:0];
    hold_last = (hold_cnt == hold_r - HOLD_W'(1));
  end

  // Envelope FSM with registered duty, strobe and end-of-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      duty       <= '0;
      duty_stb   <= 1'b0;
      cycle_done <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      duty_stb   <= 1'b0;
      cycle_done <= 1'b0;
      if (st != ST_IDLE && !en) begin
        st       <= ST_IDLE;
        duty     <= '0;
        duty_stb <= (duty != '0);
      end else begin
        case (st)
          ST_IDLE: begin
            if (en) begin
              st   <= ST_RAMP_UP;
              duty <= '0;
            end
          end
          ST_RAMP_UP: begin
            if (tick) begin
              duty     <= up_next;
              duty_stb <= (up_next != duty);
              if (up_next == DUTY_TOP) begin
                st       <= ST_HOLD_HI;
                hold_cnt <= '0;
              end
            end
          end
          ST_HOLD_HI: begin
            if (tick) begin
              if (hold_last) st <= ST_RAMP_DOWN;
              else           hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          ST_RAMP_DOWN: begin
            if (tick) begin
              duty     <= dn_next;
              duty_stb <= (dn_next != duty);
              if (dn_next == '0) begin
                st       <= ST_HOLD_LO;
                hold_cnt <= '0;
              end
            end
          end
          ST_HOLD_LO: begin
            if (tick) begin
              if (hold_last) begin
                st         <= ST_RAMP_UP;
                cycle_done <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

  pwm_gen #(
    .DUTY_W (DUTY_W)
  ) u_pwm_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (pwm_clr),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_pwm_breathe_seq.sv
// Directed bench for pwm_breathe_seq; expectations are hand-derived cycle
// counts relative to the first edge after en is raised (cyc = 0).
module tb_pwm_breathe_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_step;
  logic [7:0]  cfg_hold;
  logic [7:0]  duty;
  logic        duty_stb;
  logic        pwm_out;
  logic        nLED;
  logic [2:0]  state;
  logic        cycle_done;

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned cyc;
  int unsigned hi_cnt;
  int unsigned lo_cnt;
  int unsigned exp_half;

  // Saturation run: div=1, step=64, hold=2
  int unsigned exp_st [14] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1, 1};
  int unsigned exp_du [14] = '{0, 64, 128, 192, 255, 255, 255, 191, 127, 63, 0, 0, 0, 64};
  int unsigned exp_cd [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int unsigned exp_sb [14] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1};

  pwm_breathe_seq dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_step   (cfg_step),
    .cfg_hold   (cfg_hold),
    .duty       (duty),
    .duty_stb   (duty_stb),
    .pwm_out    (pwm_out),
    .nLED       (nLED),
    .state      (state),
    .cycle_done (cycle_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input bit with_cfg, input logic [15:0] d,
                           input logic [7:0] s, input logic [7:0] h);
    cfg_valid = with_cfg;
    cfg_div   = d;
    cfg_step  = s;
    cfg_hold  = h;
    en        = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cyc       = 0;
  endtask

  task automatic stop_run();
    en = 1'b0;
    step_clk();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
`ifdef PWM_BREATHE_GAMMA_EN
    exp_half  = 64;
`else
    exp_half  = 128;
`endif
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_step  = '0;
    cfg_hold  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_duty", duty, 0);
    check_eq("rst_nled", nLED, 1);
    check_eq("rst_pwm", pwm_out, 0);
    check_eq("rst_ready", cfg_ready, 1);
    check_eq("rst_state", state, 0);
    check_eq("rst_stb", duty_stb, 0);
    check_eq("rst_cdone", cycle_done, 0);
    rst = 1'b0;
    step_clk();
    check_eq("idle_state", state, 0);

    // Default divider: first step after 23529 clocks
    start_run(1'b0, 16'd0, 8'd0, 8'd0);
    check_eq("def_start_state", state, 1);
    while (!duty_stb && cyc < 30000) step_clk();
    check_eq("def_first_stb_cyc", cyc, 23529);
    check_eq("def_first_duty", duty, 1);
    stop_run();
    check_eq("def_abort_state", state, 0);
    check_eq("def_abort_duty", duty, 0);

    // Zero config fields behave as 1
    start_run(1'b1, 16'd0, 8'd0, 8'd0);
    step_clk();
    check_eq("zero_cfg_duty1", duty, 1);
    step_clk();
    step_clk();
    check_eq("zero_cfg_duty3", duty, 3);
    stop_run();

    // Saturating envelope, config accepted on the same cycle as en
    start_run(1'b1, 16'd1, 8'd64, 8'd2);
    check_eq("sat_ready_running", cfg_ready, 0);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) step_clk();
      check_eq($sformatf("sat_state[%0d]", i), state, exp_st[i]);
      check_eq($sformatf("sat_duty[%0d]", i), duty, exp_du[i]);
      check_eq($sformatf("sat_cdone[%0d]", i), cycle_done, exp_cd[i]);
      check_eq($sformatf("sat_stb[%0d]", i), duty_stb, exp_sb[i]);
    end

    // Config offer while running is dropped; abort in RAMP_DOWN
    while (cyc < 18) step_clk();
    check_eq("run_state_c18", state, 3);
    cfg_valid = 1'b1;
    cfg_div   = 16'd5;
    cfg_step  = 8'd1;
    cfg_hold  = 8'd9;
    check_eq("run_cfg_ready", cfg_ready, 0);
    step_clk();
    check_eq("run_duty_c19", duty, 191);
    cfg_valid = 1'b0;
    en        = 1'b0;
    step_clk();
    check_eq("abort_state", state, 0);
    check_eq("abort_duty", duty, 0);
    check_eq("abort_pwm", pwm_out, 0);
    check_eq("abort_cdone", cycle_done, 0);
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      hi_cnt += cycle_done;
    end
    check_eq("abort_no_cdone", hi_cnt, 0);

    // Restart keeps div=1/step=64/hold=2
    start_run(1'b0, 16'd0, 8'd0, 8'd0);
    check_eq("keep_duty_c0", duty, 0);
    step_clk();
    check_eq("keep_duty_c1", duty, 64);
    while (cyc < 4) step_clk();
    check_eq("keep_state_c4", state, 2);
    while (cyc < 6) step_clk();
    check_eq("keep_state_c6", state, 3);
    stop_run();

    // PWM at duty 0 for 3+ periods, then 255 applied only after the wrap
    start_run(1'b1, 16'd800, 8'd255, 8'd10);
    hi_cnt = pwm_out;
    while (cyc < 1020) begin
      step_clk();
      hi_cnt += pwm_out;
      if (cyc == 799) check_eq("pwm0_duty_c799", duty, 0);
      if (cyc == 800) begin
        check_eq("pwm_full_duty_c800", duty, 255);
        check_eq("pwm_full_state_c800", state, 2);
      end
    end
    check_eq("pwm0_high_clocks", hi_cnt, 0);
    step_clk();
    check_eq("pwm_full_first_high", pwm_out, 1);
    lo_cnt = 0;
    while (cyc < 1785) begin
      step_clk();
      lo_cnt += (pwm_out == 1'b0) ? 1 : 0;
    end
    check_eq("pwm_full_low_clocks", lo_cnt, 0);
    while (cyc < 1800) step_clk();
    check_eq("pwm_before_abort", pwm_out, 1);
    stop_run();
    check_eq("pwm_abort_pwm", pwm_out, 0);
    check_eq("pwm_abort_nled", nLED, 1);
    check_eq("pwm_abort_state", state, 0);

    // Duty 128: high clocks over one full period
    start_run(1'b1, 16'd800, 8'd128, 8'd1);
    while (cyc < 800) step_clk();
    check_eq("half_duty_c800", duty, 128);
    while (cyc < 1020) step_clk();
    hi_cnt = 0;
    while (cyc < 1275) begin
      step_clk();
      hi_cnt += pwm_out;
    end
    check_eq("half_high_clocks", hi_cnt, exp_half);
    stop_run();

    // Async reset mid-ramp restores defaults
    start_run(1'b1, 16'd1, 8'd64, 8'd2);
    step_clk();
    step_clk();
    check_eq("mid_duty_pre_rst", duty, 128);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_duty", duty, 0);
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_nled", nLED, 1);
    check_eq("async_rst_ready", cfg_ready, 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_run(1'b0, 16'd0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) step_clk();
    check_eq("post_rst_state", state, 1);
    check_eq("post_rst_default_div", duty, 0);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
